// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP framing constants, build FSM states and byte helpers
// used by the TX frame builder and the RX parser.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [31:0] PREAMBLE_W0    = 32'h5555_5555;
    localparam logic [31:0] PREAMBLE_W1    = 32'h5555_55D5;
    localparam int unsigned ETH_HDR_WORDS  = 13;

    typedef enum logic [2:0] {
        StIdle,
        StCsum,
        StHdr,
        StPay,
        StTail,
        StDone
    } build_state_e;

    // Swap the high and low nibble of every byte, e.g. 0xD5 -> 0x5D.
    function automatic logic [31:0] nibble_swap32(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = {w[8*i +: 4], w[8*i+4 +: 4]};
        end
        return r;
    endfunction

endpackage

// File: rtl/ip_csum16.sv
// Serial ones-complement accumulator for the IPv4 header checksum: clear, add one
// halfword per cycle, then fold twice and invert into a registered result.
module ip_csum16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add,
    input  logic        fold,
    input  logic [15:0] data,
    output logic [15:0] csum
);

    logic [31:0] acc_q;
    logic [15:0] csum_q;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // The second fold cannot carry out again: 0xFFFE + 1 at most.
    always_comb begin
        fold1 = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
        fold2 = fold1[15:0] + {15'b0, fold1[16]};
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else begin
            if (add) begin
                acc_q <= acc_q + {16'b0, data};
            end
            if (fold) begin
                csum_q <= ~fold2;
            end
        end
    end

    assign csum = csum_q;

endmodule

// File: rtl/eth_frame_build.sv
// Builds a preamble + Ethernet II + IPv4 + UDP frame image around a payload in TX RAM.
// Define ETH_BUILD_IP_CSUM_EN to compute the IPv4 header checksum; otherwise it is 0000.
module eth_frame_build
    import eth_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_0102,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0101,
    parameter logic [15:0] SRC_PORT    = 16'h1F90,
    parameter logic [15:0] DST_PORT    = 16'h1F91,
    parameter logic [7:0]  TTL         = 8'h40,
    parameter int unsigned PAYLOAD_MAX = 366
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] payload_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] last_addr,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PAY_MAX  = ADDR_W'(PAYLOAD_MAX);
    localparam logic [ADDR_W-1:0] HDR_LAST = ADDR_W'(ETH_HDR_WORDS - 1);

    build_state_e      state_q;
    logic [ADDR_W-1:0] len_q;
    logic [15:0]       ident_q;
    logic [15:0]       hold_q;
    logic [31:0]       hdr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic              wr_ena_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              len_ok;
    logic [15:0]       len16;
    logic [15:0]       tot_len;
    logic [15:0]       udp_len;
    logic [15:0]       ip_csum;
    logic [ADDR_W-1:0] pay_last;

    assign len_ok   = (payload_len != '0) && (payload_len <= PAY_MAX);
    assign len16    = 16'(len_q);
    assign tot_len  = (len16 << 2) + 16'd28;
    assign udp_len  = (len16 << 2) + 16'd8;
    assign pay_last = HDR_LAST + len_q;

    function automatic logic [31:0] hdr_word(input logic [3:0] idx, input logic [15:0] tlen,
                                             input logic [15:0] ulen, input logic [15:0] id,
                                             input logic [15:0] cs);
        case (idx)
            4'd0:    return PREAMBLE_W0;
            4'd1:    return PREAMBLE_W1;
            4'd2:    return DST_MAC[47:16];
            4'd3:    return {DST_MAC[15:0], SRC_MAC[47:32]};
            4'd4:    return SRC_MAC[31:0];
            4'd5:    return {SRC_MAC[15:0], ETHERTYPE_IPV4};
            4'd6:    return {16'h4500, tlen};
            4'd7:    return {id, 16'h4000};
            4'd8:    return {TTL, IP_PROTO_UDP, cs};
            4'd9:    return SRC_IP;
            4'd10:   return DST_IP;
            4'd11:   return {SRC_PORT, DST_PORT};
            4'd12:   return {ulen, 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

`ifdef ETH_BUILD_IP_CSUM_EN
    localparam logic [3:0] CSUM_FOLD = 4'd10;

    logic [3:0]  cnt_q;
    logic [15:0] csum_hw;

    // Header halfwords in wire order, checksum field taken as zero.
    always_comb begin
        case (cnt_q)
            4'd0:    csum_hw = 16'h4500;
            4'd1:    csum_hw = tot_len;
            4'd2:    csum_hw = ident_q;
            4'd3:    csum_hw = 16'h4000;
            4'd4:    csum_hw = {TTL, IP_PROTO_UDP};
            4'd6:    csum_hw = SRC_IP[31:16];
            4'd7:    csum_hw = SRC_IP[15:0];
            4'd8:    csum_hw = DST_IP[31:16];
            4'd9:    csum_hw = DST_IP[15:0];
            default: csum_hw = 16'h0000;
        endcase
    end

    ip_csum16 u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state_q == StIdle) && start && len_ok),
        .add  ((state_q == StCsum) && (cnt_q < CSUM_FOLD)),
        .fold ((state_q == StCsum) && (cnt_q == CSUM_FOLD)),
        .data (csum_hw),
        .csum (ip_csum)
    );
`else
    assign ip_csum = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            ident_q     <= '0;
            hold_q      <= '0;
            hdr_q       <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            last_addr_q <= '0;
            wr_ena_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ETH_BUILD_IP_CSUM_EN
            cnt_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && len_ok) begin
                        len_q  <= payload_len;
                        busy_q <= 1'b1;
`ifdef ETH_BUILD_IP_CSUM_EN
                        cnt_q   <= '0;
                        state_q <= StCsum;
`else
                        state_q   <= StHdr;
                        wr_ena_q  <= 1'b1;
                        wr_addr_q <= '0;
                        hdr_q     <= nibble_swap32(PREAMBLE_W0);
`endif
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
`ifdef ETH_BUILD_IP_CSUM_EN
                StCsum: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == CSUM_FOLD) begin
                        state_q   <= StHdr;
                        wr_ena_q  <= 1'b1;
                        wr_addr_q <= '0;
                        hdr_q     <= nibble_swap32(PREAMBLE_W0);
                    end
                end
`endif
                StHdr: begin
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    if (wr_addr_q == HDR_LAST) begin
                        state_q   <= StPay;
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        hold_q    <= 16'h0000;
                    end else begin
                        hdr_q <= nibble_swap32(hdr_word(4'(wr_addr_q + ADDR_W'(1)), tot_len,
                                                        udp_len, ident_q, ip_csum));
                        // P0 must be requested while w12 is on the bus.
                        if (wr_addr_q == HDR_LAST - ADDR_W'(1)) begin
                            rd_addr_q <= '0;
                        end
                    end
                end
                StPay: begin
                    hold_q    <= rd_data[15:0];
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    if (wr_addr_q == pay_last) begin
                        state_q <= StTail;
                    end
                end
                StTail: begin
                    state_q     <= StDone;
                    wr_ena_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    last_addr_q <= wr_addr_q;
                    ident_q     <= ident_q + 16'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Payload words come straight from the RAM read port, realigned by two bytes.
    always_comb begin
        case (state_q)
            StPay:   wr_data = nibble_swap32({hold_q, rd_data[31:16]});
            StTail:  wr_data = nibble_swap32({hold_q, 16'h0000});
            default: wr_data = hdr_q;
        endcase
    end

    assign rd_addr   = rd_addr_q;
    assign wr_addr   = wr_addr_q;
    assign wr_ena    = wr_ena_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign last_addr = last_addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_eth_frame_build.sv
// Directed bench for eth_frame_build: frame images, rejects, busy-start, mid-frame reset.
module tb_eth_frame_build;

`ifdef ETH_BUILD_IP_CSUM_EN
    localparam int LAT = 12;
    localparam bit CS_ON = 1'b1;
`else
    localparam int LAT = 1;
    localparam bit CS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  payload_len;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic [31:0] wr_data;
    logic [9:0]  wr_addr;
    logic        wr_ena;
    logic        busy;
    logic        done;
    logic [9:0]  last_addr;
    logic        err;

    eth_frame_build dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .payload_len (payload_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_data     (wr_data),
        .wr_addr     (wr_addr),
        .wr_ena      (wr_ena),
        .busy        (busy),
        .done        (done),
        .last_addr   (last_addr),
        .err         (err)
    );

    always #5 clk = ~clk;

    logic [31:0] pmem   [0:1023];
    logic [31:0] tx_mem [0:1023];
    logic [31:0] pay    [0:3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_total = 0;
    int rise_total = 0;
    int done_total = 0;
    int err_total = 0;
    int busy_total = 0;
    int first_wr = 0;
    int last_wr = 0;
    int done_cyc = 0;
    logic [9:0] first_addr = '0;
    logic wr_prev = 1'b0;

    always @(posedge clk) rd_data <= pmem[rd_addr];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        wr_prev <= wr_ena;
        if (wr_ena) begin
            tx_mem[wr_addr] <= wr_data;
            wr_total        <= wr_total + 1;
            last_wr         <= cyc;
            if (!wr_prev) begin
                rise_total <= rise_total + 1;
                first_wr   <= cyc;
                first_addr <= wr_addr;
            end
        end
        if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
        if (err)  err_total  <= err_total + 1;
        if (busy) busy_total <= busy_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] swap(input logic [31:0] w);
        return ((w & 32'h0F0F_0F0F) << 4) | ((w >> 4) & 32'h0F0F_0F0F);
    endfunction

    function automatic logic [31:0] exp_pre(input int idx, input int n, input logic [15:0] id,
                                            input logic [15:0] cs);
        case (idx)
            0:  return 32'h5555_5555;
            1:  return 32'h5555_55D5;
            2:  return 32'hFFFF_FFFF;
            3:  return 32'hFFFF_0200;
            4:  return 32'h0000_0001;
            5:  return 32'h0001_0800;
            6:  return {16'h4500, 16'(28 + 4 * n)};
            7:  return {id, 16'h4000};
            8:  return {16'h4011, cs};
            9:  return 32'hC0A8_0102;
            10: return 32'hC0A8_0101;
            11: return 32'h1F90_1F91;
            12: return {16'(8 + 4 * n), 16'h0000};
            default: begin
                if (idx == 13 + n) return {pay[n-1][15:0], 16'h0000};
                if (idx == 13)     return {16'h0000, pay[0][31:16]};
                return {pay[idx-14][15:0], pay[idx-13][31:16]};
            end
        endcase
    endfunction

    task automatic load_payload(input int n);
        for (int i = 0; i < n; i++) pmem[i] = pay[i];
    endtask

    task automatic verify_words(input string tag, input int n, input logic [15:0] id,
                                input logic [15:0] cs);
        for (int i = 0; i < 14 + n; i++) begin
            check($sformatf("%s_w%0d", tag, i), tx_mem[i], swap(exp_pre(i, n, id, cs)));
        end
        check({tag, "_last_addr"}, 32'(last_addr), 32'(13 + n));
    endtask

    task automatic run_frame(input string tag, input int n, input logic [15:0] id,
                             input logic [15:0] cs);
        int wb, db, rb, bb, eb, sc, k;
        wb = wr_total; db = done_total; rb = rise_total; bb = busy_total; eb = err_total;
        load_payload(n);
        payload_len = 10'(n);
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done_total == db && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check({tag, "_done_cnt"}, 32'(done_total - db), 32'd1);
        check({tag, "_wr_cnt"}, 32'(wr_total - wb), 32'(14 + n));
        check({tag, "_wr_bursts"}, 32'(rise_total - rb), 32'd1);
        check({tag, "_first_addr"}, 32'(first_addr), 32'd0);
        check({tag, "_first_cyc"}, 32'(first_wr - sc), 32'(LAT));
        check({tag, "_span"}, 32'(last_wr - first_wr), 32'(13 + n));
        check({tag, "_done_cyc"}, 32'(done_cyc - last_wr), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_total - bb), 32'(LAT - 1 + 14 + n));
        check({tag, "_no_err"}, 32'(err_total - eb), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        verify_words(tag, n, id, cs);
    endtask

    initial begin
        int db, wb, bb, eb, k;
        bit seen;
        for (int i = 0; i < 1024; i++) pmem[i] = '0;
        rst = 1'b1;
        start = 1'b0;
        payload_len = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_ena", 32'(wr_ena), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_last_addr", 32'(last_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // N=1, ident 0.
        pay[0] = 32'hDEAD_BEEF;
        run_frame("A", 1, 16'h0000, CS_ON ? 16'hB779 : 16'h0000);
        check("A_w1_hand", tx_mem[1], 32'h5555_555D);
        check("A_w13_hand", tx_mem[13], swap(32'h0000_DEAD));
        check("A_w14_hand", tx_mem[14], swap(32'hBEEF_0000));

        // N=3, ident 1.
        pay[0] = 32'h1122_3344; pay[1] = 32'h5566_7788; pay[2] = 32'h99AA_BBCC;
        run_frame("B", 3, 16'h0001, CS_ON ? 16'hB770 : 16'h0000);
        check("B_w15_hand", tx_mem[15], swap(32'h7788_99AA));

        // Rejected lengths: 0 and PAYLOAD_MAX+1.
        wb = wr_total; bb = busy_total; eb = err_total;
        payload_len = 10'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rej0_err_pulse", 32'(err), 32'd1);
        @(negedge clk);
        check("rej0_err_clear", 32'(err), 32'd0);
        payload_len = 10'd367;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rej367_err_pulse", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        check("rej_err_cnt", 32'(err_total - eb), 32'd2);
        check("rej_no_writes", 32'(wr_total - wb), 32'd0);
        check("rej_no_busy", 32'(busy_total - bb), 32'd0);
        check("rej_last_addr_held", 32'(last_addr), 32'd16);

        // start held high for the whole build: one frame, ident 2.
        pay[0] = 32'hA1B2_C3D4; pay[1] = 32'h0F1E_2D3C;
        load_payload(2);
        db = done_total; wb = wr_total; eb = err_total;
        payload_len = 10'd2;
        start = 1'b1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 3000) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("busy_start_done_cnt", 32'(done_total - db), 32'd1);
        check("busy_start_wr_cnt", 32'(wr_total - wb), 32'd16);
        check("busy_start_no_err", 32'(err_total - eb), 32'd0);
        verify_words("C", 2, 16'h0002, CS_ON ? 16'hB773 : 16'h0000);

        // Reset during the write of w5 aborts the frame.
        pay[0] = 32'hDEAD_BEEF;
        load_payload(1);
        db = done_total;
        payload_len = 10'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(wr_ena === 1'b1 && wr_addr === 10'd5) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_w5", 32'(wr_addr), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_wr_ena", 32'(wr_ena), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_total - db), 32'd0);
        run_frame("D", 1, 16'h0000, CS_ON ? 16'hB779 : 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
